// File: rtl/prover_compute_v_inbuf.sv
// Double-buffered feeder for the per-input V shift-register bank: fills a shadow buffer, swaps it into
// in_vals when the bank is idle, and sequences restart/tau/en per round. Optional: PROVER_V_INBUF_RANGE_CHECK_EN.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFFFFFFFFFFFFFF
`endif

module prover_compute_v_inbuf #(
  parameter int unsigned nCopyBits = 2,
  parameter int unsigned nCopies   = 1 << nCopyBits
) (
  input  logic                                clk,
  input  logic                                rstb,
  input  logic                                wr_en,
  input  logic [`F_NBITS-1:0]                 wr_data,
  output logic                                wr_ready,
  input  logic [`F_NBITS-1:0]                 tau_in,
  input  logic                                tau_valid,
  output logic                                tau_ready,
  input  logic                                sr_ready,
  output logic [nCopies-1:0][`F_NBITS-1:0]    in_vals,
  output logic [`F_NBITS-1:0]                 tau,
  output logic [`F_NBITS-1:0]                 m_tau_p1,
  output logic                                sr_restart,
  output logic                                sr_en,
  output logic [nCopyBits-1:0]                round,
  output logic                                busy,
  output logic                                done_pulse,
  output logic                                wr_err
);
  localparam int unsigned FW = `F_NBITS;
  localparam int unsigned PW = nCopyBits;
  localparam logic [FW-1:0] FQ = FW'(`F_Q);
  localparam logic [PW-1:0] LAST_PTR   = PW'(nCopies - 1);
  localparam logic [PW-1:0] LAST_ROUND = PW'(nCopyBits - 1);

  // Elaboration guard: the bank needs at least two rounds and nCopies must track nCopyBits.
  if (nCopyBits < 2 || nCopies != (32'd1 << nCopyBits)) begin : g_bad_param
    $error("prover_compute_v_inbuf: nCopyBits must be >= 2 and nCopies must equal 1 << nCopyBits");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESTART,
    S_WAIT_TAU,
    S_STEP,
    S_WAIT_DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [nCopies-1:0][FW-1:0]     shadow_q, shadow_d;
  logic [nCopies-1:0][FW-1:0]     active_q, active_d;
  logic [PW-1:0]                  wr_ptr_q, wr_ptr_d;
  logic                           shadow_full_q, shadow_full_d;
  logic [FW-1:0]                  tau_q, tau_d;
  logic [FW-1:0]                  m_tau_p1_q, m_tau_p1_d;
  logic                           sr_restart_q, sr_restart_d;
  logic                           sr_en_q, sr_en_d;
  logic [PW-1:0]                  round_q, round_d;
  logic                           done_q, done_d;
  logic                           sr_ready_dly_q;
  logic                           wr_fire;
  logic                           sr_rise;

  assign wr_fire = wr_en & ~shadow_full_q;
  assign sr_rise = sr_ready & ~sr_ready_dly_q;

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    wr_ptr_d      = wr_ptr_q;
    shadow_full_d = shadow_full_q;
    tau_d         = tau_q;
    m_tau_p1_d    = m_tau_p1_q;
    round_d       = round_q;
    done_d        = 1'b0;

    if (wr_fire) begin
      shadow_d[wr_ptr_q] = wr_data;
      wr_ptr_d           = wr_ptr_q + PW'(1);
      if (wr_ptr_q == LAST_PTR) shadow_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (shadow_full_q && sr_ready) begin
          active_d      = shadow_q;
          shadow_full_d = 1'b0;
          round_d       = '0;
          state_d       = S_RESTART;
        end
      end
      S_RESTART: state_d = S_WAIT_TAU;
      S_WAIT_TAU: begin
        if (tau_valid && sr_ready) begin
          tau_d = tau_in;
          // 0 and 1 are special-cased so F_Q + 1 - tau never needs a final reduction.
          if (tau_in == '0)            m_tau_p1_d = FW'(1);
          else if (tau_in == FW'(1))   m_tau_p1_d = '0;
          else                         m_tau_p1_d = FQ + FW'(1) - tau_in;
          state_d = S_STEP;
        end
      end
      S_STEP: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (sr_rise) begin
          if (round_q == LAST_ROUND) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            round_d = round_q + PW'(1);
            state_d = S_WAIT_TAU;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    sr_restart_d = (state_d == S_RESTART);
    sr_en_d      = (state_d == S_STEP);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q        <= S_IDLE;
      shadow_q       <= '0;
      active_q       <= '0;
      wr_ptr_q       <= '0;
      shadow_full_q  <= 1'b0;
      tau_q          <= '0;
      m_tau_p1_q     <= FW'(1);
      sr_restart_q   <= 1'b0;
      sr_en_q        <= 1'b0;
      round_q        <= '0;
      done_q         <= 1'b0;
      sr_ready_dly_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      wr_ptr_q       <= wr_ptr_d;
      shadow_full_q  <= shadow_full_d;
      tau_q          <= tau_d;
      m_tau_p1_q     <= m_tau_p1_d;
      sr_restart_q   <= sr_restart_d;
      sr_en_q        <= sr_en_d;
      round_q        <= round_d;
      done_q         <= done_d;
      sr_ready_dly_q <= sr_ready;
    end
  end

`ifdef PROVER_V_INBUF_RANGE_CHECK_EN
  // Sticky flag for out-of-field writes; the value is still stored.
  logic wr_err_q, wr_err_d;
  assign wr_err_d = wr_err_q | (wr_fire & (wr_data >= FQ));
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) wr_err_q <= 1'b0;
    else       wr_err_q <= wr_err_d;
  end
  assign wr_err = wr_err_q;
`else
  assign wr_err = 1'b0;
`endif

  assign wr_ready   = ~shadow_full_q;
  assign tau_ready  = (state_q == S_WAIT_TAU) & sr_ready;
  assign in_vals    = active_q;
  assign tau        = tau_q;
  assign m_tau_p1   = m_tau_p1_q;
  assign sr_restart = sr_restart_q;
  assign sr_en      = sr_en_q;
  assign round      = round_q;
  assign busy       = (state_q != S_IDLE);
  assign done_pulse = done_q;

endmodule
